debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  N-channel synchronise + debounce + edge-event block for buttons/switches.
//  Generalises single-channel sync/debounce: parametrised channel count, sync depth, stable time.
//  Adds one-cycle rise/fall event pulses and a per-channel mask.
//  Sits between board I/O pins and control FSMs (frame send trigger, key select, mode switches).
// PARAMETERS
//  N_CH          4        number of independent channels
//  NSYNC         3        synchroniser flop depth per channel (>=2)
//  STABLE_CYCLES 650000   cycles input must be unchanged before clean output follows (>=2)
//  HOLD_CYCLES   50000000 long-press threshold in cycles (used only with DEBOUNCE_LONG_PRESS_EN)
// PORTS
//  clk        in   1     system clock
//  reset      in   1     synchronous, active-high reset
//  in         in   N_CH  raw asynchronous inputs
//  mask       in   N_CH  1 = channel frozen: clean held, no events
//  clean      out  N_CH  debounced level
//  rise       out  N_CH  1-cycle pulse when clean goes 0->1
//  fall       out  N_CH  1-cycle pulse when clean goes 1->0
//  any_event  out  1     OR of all rise|fall (registered alongside them)
//  long_press out  N_CH  1-cycle pulse on hold threshold (macro only; tied 0 otherwise)
// BEHAVIOUR
//  - Reset: sync flops, candidate, counters, clean, rise, fall, any_event, long_press all 0.
//  - Per channel, per clk: synced = in after NSYNC flops.
//  - synced != candidate: candidate <= synced, count <= 0.
//  - else count < STABLE_CYCLES-1: count++.
//  - else (count == STABLE_CYCLES-1, saturated): if clean != candidate, clean <= candidate,
//    rise or fall pulses for exactly one cycle in the same edge.
//  - Latency in-edge to clean-edge: NSYNC + STABLE_CYCLES + 1 cycles, for a clean step.
//  - Any glitch with synced held shorter than STABLE_CYCLES cycles: no clean change, no event.
//  - count width $clog2(STABLE_CYCLES); saturates, never wraps.
//  - mask=1: sync/candidate/count keep running; clean, rise, fall, long_press frozen (pulses 0).
//    On unmask, if saturated and candidate != clean, clean updates on next edge with event.
//  - Channels fully independent; simultaneous events on several channels all reported.
//  - any_event = |(rise|fall), computed from the next-state values, so it asserts in the same cycle as them.
//  - reset asserted mid-count: everything returns to 0 next edge; a held-high input re-debounces
//    from scratch, producing rise after NSYNC+STABLE_CYCLES+1 cycles.
// CONFIGURATION
//  - DEBOUNCE_LONG_PRESS_EN defined: per-channel hold counter, width $clog2(HOLD_CYCLES+1).
//    Counter clears while clean=0; increments while clean=1 and unmasked; long_press pulses
//    once when it reaches HOLD_CYCLES, then saturates (one pulse per press). Hold counter
//    retains its value while masked.
//  - Undefined: no hold counter logic; long_press tied to 0; HOLD_CYCLES unused.
// STRUCTURE
//  - util_pkg: counter-width helper function and default constants (DEF_NSYNC, DEF_STABLE_CYCLES,
//    DEF_HOLD_CYCLES).
//  - Sub-module debounce_chan: one channel (sync chain, candidate, counter, clean, rise/fall,
//    optional hold counter). Top generates N_CH instances and the any_event OR.
// TESTING (N_CH=4, NSYNC=2, STABLE_CYCLES=4, HOLD_CYCLES=20, macro on and off)
//  1 in[0] 0->1 held -> clean[0]=1 and rise[0] 1-cycle pulse 7 cycles after edge; any_event same cycle.
//  2 in[1] high for 3 cycles then low -> clean[1] stays 0; rise/fall/any_event never assert.
//  3 in[3:0] 0000->1111 same edge -> rise=1111 in one cycle; release -> fall=1111 7 cycles later.
//  4 mask[2]=1, in[2] 0->1 -> no change; unmask after 20 cycles -> clean[2]=1, rise[2] next edge.
//  5 in[0] held high, reset pulsed 5 cycles after clean rose -> clean[0]=0, then rise 7 cycles after
//    reset deasserts.
//  6 macro on: in[3] held 40 cycles -> single long_press[3] pulse 20 cycles after clean[3] rises;
//    macro off: long_press stays 0.

Source files
------------

// File: rtl/util_pkg.sv
// Shared constants and helpers for the debounce block.
//   DEF_NSYNC, DEF_STABLE_CYCLES, DEF_HOLD_CYCLES : default parameter values
//   cnt_width(n) : bits needed to index n states (minimum 1)
package util_pkg;

  localparam int DEF_NSYNC         = 3;
  localparam int DEF_STABLE_CYCLES = 650000;
  localparam int DEF_HOLD_CYCLES   = 50000000;

  // Width of a counter that must hold values 0..n-1.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser chain, candidate level with stability
// counter, debounced level, one-cycle rise/fall pulses, optional long-press.
// Optional feature macro: DEBOUNCE_LONG_PRESS_EN (hold counter + long_press).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   in          : raw asynchronous input
//   mask        : 1 = clean/rise/fall/long_press frozen; sync and counter still run
//   clean       : debounced level (registered)
//   rise, fall  : registered one-cycle pulses on clean 0->1 / 1->0
//   rise_next   : value rise takes at the next edge (for the bank-wide OR)
//   fall_next   : value fall takes at the next edge
//   long_press  : one-cycle pulse when clean has been 1 for HOLD_CYCLES unmasked cycles
module debounce_chan
  import util_pkg::*;
#(
  parameter int NSYNC         = DEF_NSYNC,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic mask,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic rise_next,
  output logic fall_next,
  output logic long_press
);

  localparam int            CW      = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [NSYNC-1:0] sync_q;
  logic             synced;
  logic             candidate;
  logic [CW-1:0]    count;
  logic             saturated;
  logic             update;

  assign synced = sync_q[NSYNC-1];

  // Saturated means synced has matched the candidate for STABLE_CYCLES edges.
  assign saturated = (synced == candidate) && (count == CNT_MAX);
  assign update    = saturated && !mask && (clean != candidate);
  assign rise_next = update && candidate;
  assign fall_next = update && !candidate;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      candidate <= 1'b0;
      count     <= '0;
      clean     <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_q <= {sync_q[NSYNC-2:0], in};
      if (synced != candidate) begin
        candidate <= synced;
        count     <= '0;
      end else if (count != CNT_MAX) begin
        count <= count + 1'b1;
      end
      if (update) clean <= candidate;
      rise <= rise_next;
      fall <= fall_next;
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int            HW       = cnt_width(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic [HW-1:0] hold;

  // Counter saturates at HOLD_MAX so each press yields one pulse; it keeps
  // its value while masked and only clears once clean drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!clean) begin
        hold <= '0;
      end else if (!mask && (hold != HOLD_MAX)) begin
        hold <= hold + 1'b1;
        if (hold == HOLD_MAX - 1'b1) long_press <= 1'b1;
      end
    end
  end
`else
  // No hold logic in this build; the parameter is kept in the expression so
  // both builds share one parameter list.
  assign long_press = 1'b0 & (HOLD_CYCLES > 0);
`endif

endmodule

// File: rtl/debounce_bank.sv
// N-channel synchronise + debounce + edge-event bank for buttons/switches.
// Optional feature macro: DEBOUNCE_LONG_PRESS_EN (per-channel long-press pulse).
// Handshake: none; all outputs are registered levels/pulses valid every cycle.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   in[N_CH]    : raw asynchronous inputs
//   mask[N_CH]  : 1 = channel frozen (clean held, no events)
//   clean[N_CH] : debounced levels
//   rise[N_CH]  : one-cycle pulse on clean 0->1
//   fall[N_CH]  : one-cycle pulse on clean 1->0
//   any_event   : OR of all rise|fall, asserted in the same cycle as them
//   long_press[N_CH] : one-cycle hold-threshold pulse (0 when the macro is off)
module debounce_bank
  import util_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int NSYNC         = DEF_NSYNC,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] in,
  input  logic [N_CH-1:0] mask,
  output logic [N_CH-1:0] clean,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_event,
  output logic [N_CH-1:0] long_press
);

  logic [N_CH-1:0] rise_next;
  logic [N_CH-1:0] fall_next;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    debounce_chan #(
      .NSYNC        (NSYNC),
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .in        (in[g]),
      .mask      (mask[g]),
      .clean     (clean[g]),
      .rise      (rise[g]),
      .fall      (fall[g]),
      .rise_next (rise_next[g]),
      .fall_next (fall_next[g]),
      .long_press(long_press[g])
    );
  end

  // Built from the channels' next-state pulses so it lines up with rise/fall.
  always_ff @(posedge clk) begin
    if (reset) any_event <= 1'b0;
    else       any_event <= |(rise_next | fall_next);
  end

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

  localparam int N_CH   = 4;
  localparam int NSYNC  = 2;
  localparam int STABLE = 4;
  localparam int HOLD   = 20;
  // Raw samples needed to judge one clean change: NSYNC delay + STABLE+1 equal samples.
  localparam int WIN    = NSYNC + STABLE + 1;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] in_v;
  logic [N_CH-1:0] mask_v;
  logic [N_CH-1:0] clean;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            any_event;
  logic [N_CH-1:0] long_press;

  always #5 clk = ~clk;

  debounce_bank #(
    .N_CH(N_CH), .NSYNC(NSYNC), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .in(in_v), .mask(mask_v),
    .clean(clean), .rise(rise), .fall(fall),
    .any_event(any_event), .long_press(long_press)
  );

  // ---------------- check bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A channel's clean level moves to v once the raw input, as sampled at
  // edges e-NSYNC-STABLE .. e-NSYNC, was v every time (and it is unmasked).
  bit              hist [N_CH][WIN];
  logic [N_CH-1:0] m_clean, m_rise, m_fall, m_lp;
  logic            m_any;
  int              m_hold [N_CH];

  always @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int i = 0; i < WIN; i++) hist[c][i] = 1'b0;
        m_hold[c] = 0;
      end
      m_clean = '0; m_rise = '0; m_fall = '0; m_lp = '0; m_any = 1'b0;
    end else begin
      m_rise = '0; m_fall = '0; m_lp = '0;
      for (int c = 0; c < N_CH; c++) begin
        bit all_same;
        for (int i = 0; i < WIN - 1; i++) hist[c][i] = hist[c][i+1];
        hist[c][WIN-1] = in_v[c];
`ifdef DEBOUNCE_LONG_PRESS_EN
        if (!m_clean[c]) m_hold[c] = 0;
        else if (!mask_v[c]) begin
          m_hold[c] = m_hold[c] + 1;
          if (m_hold[c] == HOLD) m_lp[c] = 1'b1;
        end
`endif
        all_same = 1'b1;
        for (int i = 1; i <= STABLE; i++) if (hist[c][i] != hist[c][0]) all_same = 1'b0;
        if (all_same && !mask_v[c] && (hist[c][0] != m_clean[c])) begin
          m_clean[c] = hist[c][0];
          if (hist[c][0]) m_rise[c] = 1'b1;
          else            m_fall[c] = 1'b1;
        end
      end
      m_any = |(m_rise | m_fall);
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (checking) begin
      check("cyc_clean",      32'(clean),      32'(m_clean));
      check("cyc_rise",       32'(rise),       32'(m_rise));
      check("cyc_fall",       32'(fall),       32'(m_fall));
      check("cyc_any_event",  32'(any_event),  32'(m_any));
      check("cyc_long_press", 32'(long_press), 32'(m_lp));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; in_v = '0; mask_v = '0;
    step(1);
    checking = 1'b1;
    step(2);
    reset = 1'b0;
    check("rst_clean",      32'(clean),      32'h0);
    check("rst_rise",       32'(rise),       32'h0);
    check("rst_fall",       32'(fall),       32'h0);
    check("rst_any_event",  32'(any_event),  32'h0);
    check("rst_long_press", 32'(long_press), 32'h0);
    step(2);

    // 1: clean step on channel 0, event 7 edges after the input edge
    in_v[0] = 1'b1;
    step(6);
    check("t1_clean_before", 32'(clean), 32'h0);
    step(1);
    check("t1_clean",     32'(clean),     32'h1);
    check("t1_rise",      32'(rise),      32'h1);
    check("t1_any_event", 32'(any_event), 32'h1);
    step(1);
    check("t1_rise_one_cycle", 32'(rise), 32'h0);
    in_v[0] = 1'b0;
    step(7);
    check("t1_fall", 32'(fall), 32'h1);
    step(3);

    // 2: 3-cycle glitch on channel 1 never reaches clean
    in_v[1] = 1'b1;
    step(3);
    in_v[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t2_no_event", 32'(any_event), 32'h0);
      check("t2_clean",    32'(clean),     32'h0);
      step(1);
    end

    // 3: all channels together
    in_v = 4'hF;
    step(7);
    check("t3_rise_all", 32'(rise),      32'hF);
    check("t3_any",      32'(any_event), 32'h1);
    step(3);
    in_v = 4'h0;
    step(7);
    check("t3_fall_all",  32'(fall),  32'hF);
    check("t3_clean_low", 32'(clean), 32'h0);
    step(3);

    // 4: masked channel 2 holds, then updates right after unmask
    mask_v[2] = 1'b1;
    in_v[2]   = 1'b1;
    step(20);
    check("t4_masked_clean", 32'(clean), 32'h0);
    mask_v[2] = 1'b0;
    step(1);
    check("t4_unmask_clean", 32'(clean), 32'h4);
    check("t4_unmask_rise",  32'(rise),  32'h4);
    in_v[2] = 1'b0;
    step(10);

    // 5: reset mid-hold restarts debounce from scratch
    in_v[0] = 1'b1;
    step(7);
    check("t5_first_rise", 32'(rise), 32'h1);
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t5_reset_clean", 32'(clean), 32'h0);
    step(6);
    check("t5_not_yet", 32'(clean), 32'h0);
    step(1);
    check("t5_rerise", 32'(rise), 32'h1);
    in_v[0] = 1'b0;
    step(10);

    // 6: long press on channel 3 (clean rises 7 edges in, pulse 20 later)
    in_v[3] = 1'b1;
    step(7);
    check("t6_clean", 32'(clean), 32'h8);
    step(19);
    check("t6_lp_before", 32'(long_press), 32'h0);
    step(1);
`ifdef DEBOUNCE_LONG_PRESS_EN
    check("t6_lp_pulse", 32'(long_press), 32'h8);
`else
    check("t6_lp_off", 32'(long_press), 32'h0);
`endif
    step(1);
    check("t6_lp_single", 32'(long_press), 32'h0);
    step(12);
    in_v[3] = 1'b0;
    step(12);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
